dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Memory-stage data-memory access controller between the E/M pipeline register and the buffered data RAM.
- Issues load/store requests, waits for the RAM handshake, and captures and extends read data for the M/W register.
- Drives `mem_waiting` to the pipeline valid/flush controller, which freezes M and all earlier stages and bubbles W while an access is in flight.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Fixed at 32 for RV32.
- TIMEOUT, 15, maximum cycles in WAIT before a bus error is declared. Range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- MemRead_M  in  1  load in M stage
- MemWrite_M  in  1  store in M stage
- funct3_M  in  3  access size/sign (RV32 encoding)
- ALUResult_M  in  32  byte address
- WriteData_M  in  32  store data, unaligned (low bytes)
- ram_req  out  1  request valid
- ram_we  out  1  1 = write
- ram_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- ram_wdata  out  32  store data shifted to byte lane
- ram_wstrb  out  4  byte-enable
- ram_ready  in  1  RAM accepts request this cycle
- ram_rvalid  in  1  read data valid
- ram_rdata  in  32  raw read word
- mem_waiting  out  1  stall request to the valid controller
- ReadData_M  out  32  extended load data, held stable
- misalign_M  out  1  misaligned access flag (combinational)
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
Reset:
- state=IDLE, rbuf=0, tcnt=0.
- bus_err=0, ram_req=0, mem_waiting=0.
- While rst=1, all request outputs are forced to 0.

Access and misalignment:
- `access = (MemRead_M | MemWrite_M) & ~misalign_M`.
- `misalign_M`: half-word with addr[0]=1, or word with addr[1:0]≠0.
- A misaligned access issues no request and no stall (mem_waiting=0). The store is suppressed and ReadData_M keeps its old value.
- MemRead_M and MemWrite_M both 1: treated as a load.

FSM states: IDLE, REQ, WAIT, DONE.
- IDLE
  - If access: ram_req=1, mem_waiting=1.
  - If ram_ready: go to WAIT for a load, DONE for a store. Otherwise go to REQ.
  - Else: mem_waiting=0.
- REQ
  - ram_req=1, mem_waiting=1. Request fields are held stable from the M-stage inputs (M is frozen).
  - On ram_ready: go to WAIT for a load, DONE for a store.
- WAIT
  - ram_req=0, mem_waiting=1, tcnt increments.
  - On ram_rvalid: rbuf ← ram_rdata, go to DONE.
  - If tcnt reaches TIMEOUT: rbuf ← 0, bus_err=1 for one cycle, go to DONE.
  - rvalid and timeout in the same cycle: rvalid wins, no error.
- DONE
  - mem_waiting=0 for exactly one cycle so M advances into W. Go to IDLE. tcnt=0.
  - The new M instruction is evaluated next cycle in IDLE; back-to-back accesses lose one cycle.

Other rules:
- ram_rvalid outside WAIT is ignored. ram_ready outside IDLE/REQ is ignored.
- Minimum M residency: store 2 cycles (ready in IDLE); load 3 cycles (rvalid the cycle after accept).
- Store lanes:
  - SB: strobe 4'b0001<<addr[1:0], wdata = {4{WriteData_M[7:0]}}.
  - SH: strobe 4'b0011<<addr[1:0], wdata = {2{WriteData_M[15:0]}}.
  - SW: strobe 4'b1111, wdata = WriteData_M.
- Loads: byte/half selected from rbuf by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. funct3 values 3'b011/110/111 are treated as LW.
- ReadData_M is combinational from rbuf and the held addr/funct3. It is valid in DONE and while M is frozen.
- Reset mid-operation returns to IDLE next cycle. An outstanding ram_rvalid is dropped. The RAM must tolerate an abandoned request.

Decomposition:
- Shared package: funct3 load/store constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010), FSM state encoding (2 bits), TIMEOUT default.
- Sub-module `load_extend`: combinational byte/half select plus sign/zero extension from (rbuf, addr[1:0], funct3).

Test Plan:
- LW addr 0x100, ram_ready immediate, rvalid 1 cycle later with 0xDEADBEEF → mem_waiting high 2 cycles, then ReadData_M=0xDEADBEEF in DONE.
- LB addr 0x103 with rdata 0x80FFFFFF → 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x000080FF.
- SB addr 0x201 data 0x000000AB → ram_wstrb=4'b0010, ram_wdata=0xABABABAB, ram_addr=0x200, mem_waiting 1 cycle.
- ram_ready low 3 cycles then high → ram_req held 4 cycles with stable addr/strobe; no rvalid for 15 cycles → bus_err pulse, ReadData_M=0, then IDLE.
- SW addr 0x102 → misalign_M=1, ram_req=0, mem_waiting=0.
- rst asserted in WAIT → IDLE next cycle, ram_req=0; late rvalid ignored.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared constants and FSM encoding for the data-memory access controller
package dmem_access_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - request/response bus between the access controller and the data RAM
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ram_req;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W/8-1:0]   ram_wstrb;
    logic                  ram_ready;
    logic                  ram_rvalid;
    logic [DATA_W-1:0]     ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
        input  ram_ready, ram_rvalid, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
        output ram_ready, ram_rvalid, ram_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl_load_extend.sv
// rtl/dmem_access_ctrl_load_extend.sv - byte/half lane select with sign or zero extension for loads
module load_extend
    import dmem_access_ctrl_pkg::*;
(
    input  logic [31:0] rbuf,
    input  logic [1:0]  lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (lo)
            2'd0:    b = rbuf[7:0];
            2'd1:    b = rbuf[15:8];
            2'd2:    b = rbuf[23:16];
            default: b = rbuf[31:24];
        endcase
        h = lo[1] ? rbuf[31:16] : rbuf[15:0];
        // Reserved encodings fall through to a full-word load.
        case (funct3)
            F3_LB:   data = {{24{b[7]}}, b};
            F3_LBU:  data = {24'b0, b};
            F3_LH:   data = {{16{h[15]}}, h};
            F3_LHU:  data = {16'b0, h};
            default: data = rbuf;
        endcase
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - M-stage load/store controller: issues RAM requests, stalls the pipe, extends read data
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead_M,
    input  logic               MemWrite_M,
    input  logic [2:0]         funct3_M,
    input  logic [ADDR_W-1:0]  ALUResult_M,
    input  logic [DATA_W-1:0]  WriteData_M,
    dmem_access_ctrl_if.master ram,
    output logic               mem_waiting,
    output logic [DATA_W-1:0]  ReadData_M,
    output logic               misalign_M,
    output logic               bus_err
);
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

    state_t            state;
    logic [DATA_W-1:0] rbuf;
    logic [7:0]        tcnt;
    logic [1:0]        ld_lo;
    logic [2:0]        ld_f3;

    logic is_byte, is_half, is_word;
    logic is_load, is_store, access, req_phase;

    assign is_byte  = (funct3_M[1:0] == F3_SB[1:0]);
    assign is_half  = (funct3_M[1:0] == F3_SH[1:0]);
    assign is_word  = ~is_byte & ~is_half;
    assign is_load  = MemRead_M;
    assign is_store = MemWrite_M & ~MemRead_M;

    assign misalign_M = (MemRead_M | MemWrite_M) &
                        ((is_half & ALUResult_M[0]) | (is_word & (ALUResult_M[1:0] != 2'b00)));
    assign access     = (MemRead_M | MemWrite_M) & ~misalign_M;

    // The request is raised in IDLE itself so a store ready on first sight costs only two cycles.
    assign req_phase   = ((state == S_IDLE) & access) | (state == S_REQ);
    assign mem_waiting = ~rst & (req_phase | (state == S_WAIT));

    assign ram.ram_req  = ~rst & req_phase;
    assign ram.ram_we   = ~rst & req_phase & is_store;
    assign ram.ram_addr = rst ? '0 : {ALUResult_M[ADDR_W-1:2], 2'b00};

    always_comb begin
        ram.ram_wdata = '0;
        ram.ram_wstrb = '0;
        if (!rst) begin
            if (is_byte)      ram.ram_wdata = {4{WriteData_M[7:0]}};
            else if (is_half) ram.ram_wdata = {2{WriteData_M[15:0]}};
            else              ram.ram_wdata = WriteData_M;
            if (req_phase && is_store) begin
                if (is_byte)      ram.ram_wstrb = 4'b0001 << ALUResult_M[1:0];
                else if (is_half) ram.ram_wstrb = 4'b0011 << ALUResult_M[1:0];
                else              ram.ram_wstrb = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rbuf    <= '0;
            tcnt    <= '0;
            bus_err <= 1'b0;
            ld_lo   <= 2'b00;
            ld_f3   <= F3_LW;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (access) begin
                        // Lane/extension select is captured per load so ReadData_M stays put across stores.
                        if (is_load) begin
                            ld_lo <= ALUResult_M[1:0];
                            ld_f3 <= funct3_M;
                        end
                        tcnt <= '0;
                        if (ram.ram_ready) state <= is_load ? S_WAIT : S_DONE;
                        else               state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ram.ram_ready) state <= is_load ? S_WAIT : S_DONE;
                end
                S_WAIT: begin
                    if (ram.ram_rvalid) begin
                        rbuf  <= ram.ram_rdata;
                        state <= S_DONE;
                    end else if (tcnt == TLIM) begin
                        rbuf    <= '0;
                        bus_err <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: begin
                    tcnt  <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .rbuf   (rbuf),
        .lo     (ld_lo),
        .funct3 (ld_f3),
        .data   (ReadData_M)
    );
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - randomized self-checking bench for dmem_access_ctrl against a transaction-level model
module tb_dmem_access_ctrl;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_M, MemWrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALUResult_M, WriteData_M;
    logic        mem_waiting, misalign_M, bus_err;
    logic [31:0] ReadData_M;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rd;

    dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ram ();

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .funct3_M    (funct3_M),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .ram         (ram),
        .mem_waiting (mem_waiting),
        .ReadData_M  (ReadData_M),
        .misalign_M  (misalign_M),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int unsigned sz = size_of(f3);
        logic [31:0] v = w >> (8 * (a % 4));
        if (sz == 4) return w;
        if (sz == 1) begin
            v = v & 32'h000000FF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else begin
            v = v & 32'h0000FFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz = size_of(f3);
        if (sz == 1) return 32'(1 << (a % 4));
        if (sz == 2) return 32'(3 << (a % 4));
        return 32'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int unsigned sz = size_of(f3);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    // One M-stage instruction: RAM accepts after dready idle cycles and returns data rdelay cycles later.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int dready, input int rdelay, input logic [31:0] rw);
        bit mem   = rd | wr;
        bit mis   = mem && ((a % size_of(f3)) != 0);
        bit live  = mem && !mis;
        bit ld    = live && rd;
        bit st    = live && !rd;
        bit tmo   = 1'b0;
        int stall = 0;
        logic [31:0] exp_load = '0;
        if (ld) begin
            tmo      = rdelay > TO;
            stall    = dready + 1 + (tmo ? TO : rdelay);
            exp_load = tmo ? 32'h0 : ref_load(f3, a, rw);
        end else if (st) begin
            stall = dready + 1;
        end
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            MemRead_M   = rd;
            MemWrite_M  = wr;
            funct3_M    = f3;
            ALUResult_M = a;
            WriteData_M = wd;
            ram.ram_ready  = live && k <= dready ? (k == dready) : 1'($urandom_range(0, 1));
            ram.ram_rvalid = ld && (k == dready + rdelay);
            ram.ram_rdata  = ram.ram_rvalid ? rw : $urandom;
            #1;
            if (k < stall) begin
                check("waiting", 32'(mem_waiting), 32'd1);
                check("req", 32'(ram.ram_req), 32'(k <= dready));
                check("bus_err_busy", 32'(bus_err), 32'd0);
                if (k <= dready) begin
                    check("addr", ram.ram_addr, a & 32'hFFFFFFFC);
                    check("we", 32'(ram.ram_we), 32'(st));
                    if (st) begin
                        check("wstrb", 32'(ram.ram_wstrb), ref_strb(f3, a));
                        check("wdata", ram.ram_wdata, ref_wdata(f3, wd));
                    end
                end
            end else begin
                check("waiting_end", 32'(mem_waiting), 32'd0);
                check("req_end", 32'(ram.ram_req), 32'd0);
                check("misalign", 32'(misalign_M), 32'(mis));
                check("bus_err", 32'(bus_err), 32'(tmo));
                if (ld) exp_rd = exp_load;
                if (!st) check("rdata", ReadData_M, exp_rd);
            end
        end
    endtask

    bit          r_rd, r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd, r_rw;
    int          r_sel, r_dr, r_rl;

    initial begin
        rst = 1'b1;
        MemRead_M = 1'b1; MemWrite_M = 1'b0; funct3_M = 3'b010;
        ALUResult_M = 32'h100; WriteData_M = '0;
        ram.ram_ready = 1'b1; ram.ram_rvalid = 1'b1; ram.ram_rdata = 32'hFFFFFFFF;
        exp_rd = '0;

        repeat (3) begin
            @(negedge clk);
            check("rst_req", 32'(ram.ram_req), 32'd0);
            check("rst_waiting", 32'(mem_waiting), 32'd0);
            check("rst_bus_err", 32'(bus_err), 32'd0);
            check("rst_rdata", ReadData_M, 32'd0);
        end
        rst = 1'b0; MemRead_M = 1'b0; ram.ram_ready = 1'b0; ram.ram_rvalid = 1'b0;

        run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FFFFFF);
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FFFFFF);
        run_op(1, 0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80FFFFFF);
        run_op(0, 1, 3'b000, 32'h201, 32'hAB, 0, 1, 32'h0);
        run_op(1, 0, 3'b010, 32'h140, 32'h0, 3, TO + 1, 32'h12345678);
        run_op(0, 1, 3'b010, 32'h102, 32'h55, 0, 1, 32'h0);
        run_op(1, 0, 3'b010, 32'h180, 32'h0, 0, TO, 32'hCAFEF00D);
        run_op(1, 1, 3'b001, 32'h1A2, 32'h77, 1, 2, 32'h8001C0DE);
        run_op(0, 0, 3'b010, 32'h1A3, 32'h0, 0, 1, 32'h0);

        // Reset while the load is waiting for data; the late rvalid must be dropped.
        @(negedge clk);
        MemRead_M = 1'b1; MemWrite_M = 1'b0; funct3_M = 3'b010; ALUResult_M = 32'h300;
        ram.ram_ready = 1'b1; ram.ram_rvalid = 1'b0;
        #1 check("mr_req", 32'(ram.ram_req), 32'd1);
        @(negedge clk);
        ram.ram_ready = 1'b0; rst = 1'b1;
        #1 check("mr_req_rst", 32'(ram.ram_req), 32'd0);
        check("mr_waiting_rst", 32'(mem_waiting), 32'd0);
        @(negedge clk);
        rst = 1'b0; MemRead_M = 1'b0; ram.ram_rvalid = 1'b1; ram.ram_rdata = 32'h13572468;
        #1 check("mr_idle_req", 32'(ram.ram_req), 32'd0);
        check("mr_idle_waiting", 32'(mem_waiting), 32'd0);
        @(negedge clk);
        ram.ram_rvalid = 1'b0;
        exp_rd = 32'h0;
        #1 check("mr_rdata", ReadData_M, exp_rd);
        check("mr_waiting", 32'(mem_waiting), 32'd0);

        for (int i = 0; i < 250; i++) begin
            r_sel = $urandom_range(0, 9);
            r_rd  = r_sel < 5;
            r_wr  = r_sel >= 4 && r_sel < 9;
            r_f3  = r_rd ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            r_a   = $urandom;
            if ($urandom_range(0, 1) == 0) r_a = r_a & 32'hFFFFFFFC;
            r_wd  = $urandom;
            r_rw  = $urandom;
            r_dr  = $urandom_range(0, 3);
            r_rl  = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(1, TO);
            run_op(r_rd, r_wr, r_f3, r_a, r_wd, r_dr, r_rl, r_rw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
